lifo_word_packer: RTL and testbench



---
 rtl/lifo_word_packer_pkg.sv | 16 +
 rtl/lifo_pack_outreg.sv | 56 +++++
 rtl/lifo_word_packer.sv | 92 +++++++++
 tb/tb_lifo_word_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_word_packer_pkg.sv
// Shared constants for the lifo stack and its word packer, plus lane addressing.
package lifo_word_packer_pkg;

  localparam int unsigned LIFO_WIDTH = 8;
  localparam int unsigned PACK_LANES = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } outreg_state_t;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lifo_pack_outreg.sv
// Single-entry valid/ready output register for packed words.
module lifo_pack_outreg
  import lifo_word_packer_pkg::*;
#(
  parameter int unsigned WIDTH = LIFO_WIDTH,
  parameter int unsigned LANES = PACK_LANES,
  parameter int unsigned CNTW  = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH*LANES-1:0] load_data,
  input  logic [CNTW-1:0]        load_count,
  input  logic                   out_ready,
  output logic                   free,
  output logic                   out_valid,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [CNTW-1:0]        out_count
);

  outreg_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OUT_EMPTY;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (load) begin
            state     <= OUT_FULL;
            out_data  <= load_data;
            out_count <= load_count;
          end
        end
        OUT_FULL: begin
          if (out_ready) begin
            if (load) begin
              out_data  <= load_data;
              out_count <= load_count;
            end else begin
              state <= OUT_EMPTY;
            end
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  assign out_valid = (state == OUT_FULL);
  // Free also when the held word leaves this cycle, giving zero-bubble reloads.
  assign free      = (state == OUT_EMPTY) || out_ready;

endmodule

// File: rtl/lifo_word_packer.sv
// Pops lifo entries and packs LANES of them into one wide valid/ready word, with flush.
module lifo_word_packer
  import lifo_word_packer_pkg::*;
#(
  parameter  int unsigned WIDTH = LIFO_WIDTH,
  parameter  int unsigned LANES = PACK_LANES,
  localparam int unsigned CNTW  = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lifo_empty,
  input  logic [WIDTH-1:0]       lifo_dout,
  output logic                   lifo_read_en,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [CNTW-1:0]        out_count,
  output logic                   busy
);

  localparam logic [CNTW-1:0] FULL_FILL = CNTW'(LANES);

  logic [WIDTH*LANES-1:0] pack;
  logic [CNTW-1:0]        fill;
  logic [CNTW-1:0]        fill_avail;
  logic                   inflight;
  logic                   flush_pending;
  logic                   out_free;
  logic                   full_load;
  logic                   flush_load;
  logic                   load;
  logic                   stall;
  logic                   flush_take;

  always_comb begin
    full_load  = (fill == FULL_FILL) && out_free;
    // A full word leaving this cycle frees the whole pack register for the next pop.
    fill_avail = full_load ? '0 : fill;
    stall      = (fill == FULL_FILL) && !out_free;
    flush_load = flush_pending && !inflight && (fill != '0) && (fill != FULL_FILL) && out_free;
    load       = full_load || flush_load;
    flush_take = flush && !flush_pending && ((fill_avail != '0) || inflight);
    lifo_read_en = rst && !lifo_empty && !flush && !flush_pending && !stall &&
                   ((fill_avail + CNTW'(inflight)) < FULL_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack          <= '0;
      fill          <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      inflight <= lifo_read_en;
      if (inflight) begin
        pack[lane_lsb(32'(fill), WIDTH) +: WIDTH] <= lifo_dout;
        fill <= fill + CNTW'(1);
      end else if (load) begin
        // Cleared pack keeps unused upper lanes zero in flushed partial words.
        pack <= '0;
        fill <= '0;
      end
      if (flush_pending) begin
        if (load || (!inflight && fill == '0))
          flush_pending <= 1'b0;
      end else if (flush_take) begin
        flush_pending <= 1'b1;
      end
    end
  end

  assign busy = (fill != '0) || inflight || flush_pending;

  lifo_pack_outreg #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .CNTW (CNTW)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (pack),
    .load_count(fill),
    .out_ready (out_ready),
    .free      (out_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count)
  );

endmodule

// File: tb/tb_lifo_word_packer.sv
// Scoreboard bench for lifo_word_packer driven by a behavioural lifo stack model.
module tb_lifo_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lifo_empty;
  logic [7:0]  lifo_dout = '0;
  logic        lifo_read_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        busy;

  logic        hold;
  logic        push_en;
  logic [7:0]  push_data;
  logic [7:0]  stk [0:15];
  int unsigned sp = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  int st_total = 0, st_bad = 0;
  int mon_total = 0, mon_bad = 0;

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [2:0]  prev_cnt = '0;

  always #5 clk = ~clk;

  lifo_word_packer #(.WIDTH(8), .LANES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .lifo_empty  (lifo_empty),
    .lifo_dout   (lifo_dout),
    .lifo_read_en(lifo_read_en),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .busy        (busy)
  );

  // Stack model: hold masks it as empty while the bench is loading entries.
  assign lifo_empty = (sp == 0) || hold;

  always @(posedge clk) begin
    if (push_en) begin
      stk[sp[3:0]] <= push_data;
      sp <= sp + 1;
    end else if (lifo_read_en && !lifo_empty) begin
      lifo_dout <= stk[sp[3:0] - 4'd1];
      sp <= sp - 1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mon_total++;
      if (lifo_read_en && lifo_empty) begin
        mon_bad++;
        $display("FAIL pop_on_empty: lifo_read_en=%b with lifo_empty=1, want 0", lifo_read_en);
      end
      if (rst && prev_hold) begin
        mon_total++;
        if (!out_valid || out_data != prev_data || out_count != prev_cnt) begin
          mon_bad++;
          $display("FAIL hold_stable: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                   out_valid, out_data, out_count, prev_data, prev_cnt);
        end
      end
      prev_hold = rst && out_valid && !out_ready;
      prev_data = out_data;
      prev_cnt  = out_count;
      if (rst && out_valid && out_ready) begin
        mon_total++;
        if (exp_q.size() == 0) begin
          mon_bad++;
          $display("FAIL unexpected_word: got d=%h c=%0d want no word", out_data, out_count);
        end else begin
          e = exp_q.pop_front();
          if (out_data != e.data || out_count != e.cnt) begin
            mon_bad++;
            $display("FAIL word: got d=%h c=%0d want d=%h c=%0d", out_data, out_count, e.data, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    st_total++;
    if (act !== exp) begin
      st_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
    exp_q.push_back('{data: d, cnt: c});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b1; flush = 1'b0; out_ready = 1'b0;
    push_en = 1'b0; push_data = '0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_en", 32'(lifo_read_en), 32'd0);
    rst = 1'b1;
    tick();

    // Four entries, back-to-back pops, one full word
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_word(32'h11223344, 3'd4);
    hold = 1'b0; #1;
    chk("t1_pop0", 32'(lifo_read_en), 32'd1); tick();
    chk("t1_pop1", 32'(lifo_read_en), 32'd1); tick();
    chk("t1_pop2", 32'(lifo_read_en), 32'd1); tick();
    chk("t1_pop3", 32'(lifo_read_en), 32'd1); tick();
    chk("t1_pop4_off", 32'(lifo_read_en), 32'd0); tick();
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_count", 32'(out_count), 32'd4);
    repeat (3) tick();
    hold = 1'b1;

    // Eight entries under backpressure, then zero-bubble drain
    out_ready = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h05060708, 3'd4);
    expect_word(32'h01020304, 3'd4);
    hold = 1'b0;
    repeat (20) tick();
    chk("t2_held_valid", 32'(out_valid), 32'd1);
    chk("t2_held_data", out_data, 32'h05060708);
    chk("t2_stall_pop", 32'(lifo_read_en), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t2_nobubble_valid", 32'(out_valid), 32'd1);
    chk("t2_nobubble_data", out_data, 32'h01020304);
    repeat (3) tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    hold = 1'b1;

    // Partial word via flush
    push(8'hA1); push(8'hA2);
    expect_word(32'h0000A1A2, 3'd2);
    hold = 1'b0;
    repeat (5) tick();
    chk("t3_busy_before", 32'(busy), 32'd1);
    pulse_flush();
    repeat (4) tick();
    chk("t3_busy_after", 32'(busy), 32'd0);
    hold = 1'b1;

    // Flush while a pop is in flight with fill=1
    push(8'hB1); push(8'hB2); push(8'hB3);
    expect_word(32'h0000B2B3, 3'd2);
    expect_word(32'h000000B1, 3'd1);
    hold = 1'b0;
    tick(); tick();
    flush = 1'b1; #1;
    chk("t4_no_pop_flush", 32'(lifo_read_en), 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t4_no_pop_pending", 32'(lifo_read_en), 32'd0);
    hold = 1'b1;
    tick(); tick();
    chk("t4_busy_fell", 32'(busy), 32'd0);
    chk("t4_valid_gone", 32'(out_valid), 32'd0);
    hold = 1'b0;
    repeat (4) tick();
    pulse_flush();
    repeat (4) tick();
    chk("t4_drain_busy", 32'(busy), 32'd0);
    hold = 1'b1;

    // Flush with nothing to emit
    pulse_flush();
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Reset mid-stream with fill=3, pop in flight, word held
    out_ready = 1'b0;
    for (int unsigned i = 1; i <= 9; i++) push(8'h70 + 8'(i));
    expect_word(32'h00000071, 3'd1);
    hold = 1'b0;
    repeat (9) tick();
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_data", out_data, 32'h76777879);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_count", 32'(out_count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_read_en", 32'(lifo_read_en), 32'd0);
    tick(); tick();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) tick();
    pulse_flush();
    repeat (5) tick();
    chk("t6_end_busy", 32'(busy), 32'd0);

    repeat (3) tick();
    chk("words_outstanding", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", st_total + mon_total, st_bad + mon_bad);
    $finish;
  end

endmodule
